// File: rtl/arch_defs_pkg.sv
// Shared architecture constants for the 8-bit SAP computer, plus the program loader's
// sync byte and state encoding.
package arch_defs_pkg;

  localparam int ADDR_WIDTH = 4;
  localparam int DATA_WIDTH = 8;

  localparam logic [DATA_WIDTH-1:0] LOADER_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERROR
  } loader_state_t;

endpackage

// File: rtl/loader_timeout_counter.sv
// Inter-byte watchdog for the program loader: a down-counter reloaded on every byte or
// while disabled; expired is the terminal count while enabled and not being cleared.
module loader_timeout_counter #(
  parameter int unsigned CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LOAD = CW'(CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (!enable || clear) begin
      count_d = LOAD;
    end else if (count_q != '0) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= LOAD;
    end else begin
      count_q <= count_d;
    end
  end

  // Reload after a byte leaves count = CYCLES-1, so expiry lands CYCLES edges later.
  assign expired = enable && !clear && (count_q == '0);

endmodule

// File: rtl/program_loader.sv
// Boot-stage loader: parses A5 / N / data / checksum frames into program RAM and holds the
// CPU in reset until a verified image is in place. Inter-byte timeout under PROGRAM_LOADER_TIMEOUT_EN.
//
// state    | meaning
// ST_IDLE  | waiting for sync byte, other bytes ignored
// ST_LEN   | next byte is the image length N
// ST_DATA  | writing data bytes to RAM, accumulating checksum
// ST_CSUM  | next byte is compared against the running sum
// ST_DONE  | image verified, CPU released, input ignored until reset
// ST_ERROR | load failed, a sync byte restarts at ST_LEN
module program_loader #(
  parameter int          ADDR_WIDTH     = arch_defs_pkg::ADDR_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [arch_defs_pkg::DATA_WIDTH-1:0] rx_data,
  input  logic                                rx_valid,
  output logic                                ram_we,
  output logic [ADDR_WIDTH-1:0]               ram_addr,
  output logic [arch_defs_pkg::DATA_WIDTH-1:0] ram_wdata,
  output logic                                cpu_hold,
  output logic                                load_done,
  output logic                                load_error
);
  import arch_defs_pkg::*;

  localparam int          CW    = ADDR_WIDTH + 1;
  localparam logic [31:0] DEPTH = 32'd1 << ADDR_WIDTH;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("program_loader: TIMEOUT_CYCLES must be at least 1");
  end

  loader_state_t         state_q, state_d;
  logic [CW-1:0]         len_q, len_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  hold_q, hold_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  timeout_hit;

`ifdef PROGRAM_LOADER_TIMEOUT_EN
  logic timer_en;
  assign timer_en = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM);

  loader_timeout_counter #(
    .CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .enable (timer_en),
    .clear  (rx_valid),
    .expired(timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    done_d  = done_q;
    err_d   = err_q;
    if (rx_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          if (rx_data == LOADER_SYNC_BYTE) begin
            state_d = ST_LEN;
            cnt_d   = '0;
            sum_d   = '0;
          end
        end
        ST_LEN: begin
          if (rx_data == '0 || 32'(rx_data) > DEPTH) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end else begin
            len_d   = CW'(rx_data);
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          we_d    = 1'b1;
          addr_d  = cnt_q[ADDR_WIDTH-1:0];
          wdata_d = rx_data;
          sum_d   = sum_q + rx_data;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q + CW'(1) == len_q) begin
            state_d = ST_CSUM;
          end
        end
        ST_CSUM: begin
          if (rx_data == sum_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end
        end
        ST_DONE: begin
        end
        ST_ERROR: begin
          if (rx_data == LOADER_SYNC_BYTE) begin
            state_d = ST_LEN;
            err_d   = 1'b0;
            cnt_d   = '0;
            sum_d   = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else if (timeout_hit) begin
      state_d = ST_ERROR;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign ram_we     = we_q;
  assign ram_addr   = addr_q;
  assign ram_wdata  = wdata_q;
  assign cpu_hold   = hold_q;
  assign load_done  = done_q;
  assign load_error = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: frame-level model pushes expected RAM writes into
// a queue that a negedge monitor drains; load status is checked after each frame.
module tb_program_loader;
  import arch_defs_pkg::*;

  localparam int AW    = arch_defs_pkg::ADDR_WIDTH;
  localparam int DEPTH = 1 << AW;
  localparam int TO    = 20;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic [7:0]            rx_data = 8'h00;
  logic                  rx_valid = 1'b0;
  logic                  ram_we;
  logic [AW-1:0]         ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  cpu_hold;
  logic                  load_done;
  logic                  load_error;

  program_loader #(
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_error(load_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  exp_done = 1'b0;
  bit  exp_err = 1'b0;
  bit  rand_gaps = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    wr_t e;
    if (reset && ram_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual addr=%0h data=%0h expected no write", ram_addr, ram_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", int'(ram_addr), e.addr);
        chk("wr_data", int'(ram_wdata), e.data);
      end
    end
  end

  task automatic push_wr(input int a, input int d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b);
    int g;
    g = rand_gaps ? int'($urandom_range(0, 2)) : 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (g) @(negedge clk);
  endtask

  task automatic check_status(input string tag);
    #1;
    chk({tag, "_done"}, int'(load_done), int'(exp_done));
    chk({tag, "_error"}, int'(load_error), int'(exp_err));
    chk({tag, "_hold"}, int'(cpu_hold), int'(!exp_done));
    chk({tag, "_pending_writes"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_we"}, int'(ram_we), 0);
    chk({tag, "_addr"}, int'(ram_addr), 0);
    chk({tag, "_wdata"}, int'(ram_wdata), 0);
    chk({tag, "_hold"}, int'(cpu_hold), 1);
    chk({tag, "_done"}, int'(load_done), 0);
    chk({tag, "_error"}, int'(load_error), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // kind 0: good frame, 1: bad checksum, 2: illegal length
  task automatic run_frame(input int kind);
    int         n;
    logic [7:0] s;
    logic [7:0] b;
    if (kind == 2) begin
      if (DEPTH >= 255 || $urandom_range(0, 1) == 0) n = 0;
      else n = int'($urandom_range(DEPTH + 1, 255));
    end else begin
      n = int'($urandom_range(1, DEPTH));
    end
    send(LOADER_SYNC_BYTE);
    send(8'(n));
    if (kind == 2) begin
      if (!exp_done) exp_err = 1'b1;
      return;
    end
    s = 8'h00;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      s = s + b;
      if (!exp_done) push_wr(i, int'(b));
      send(b);
    end
    if (kind == 0) send(s);
    else send(s + 8'($urandom_range(1, 255)));
    if (!exp_done) begin
      if (kind == 0) begin
        exp_done = 1'b1;
        exp_err  = 1'b0;
      end else begin
        exp_err = 1'b1;
      end
    end
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [7:0] b;
    int         seen;

    do_reset();
    check_reset_values("reset");

    // Reference frame; bytes after DONE must be ignored.
    push_wr(0, 'h11);
    push_wr(1, 'h22);
    push_wr(2, 'h33);
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h66);
    exp_done = 1'b1;
    check_status("frame_ok");
    send(8'hA5); send(8'h01); send(8'h77); send(8'h77);
    check_status("after_done");

    do_reset();
    push_wr(0, 'h11);
    push_wr(1, 'h22);
    push_wr(2, 'h33);
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h67);
    exp_err = 1'b1;
    check_status("bad_csum");
    run_frame(0);
    check_status("recover");

    do_reset();
    send(8'h00); send(8'hFF); send(8'h5A);
    push_wr(0, 'hA5);
    send(8'hA5); send(8'h01); send(8'hA5); send(8'hA5);
    exp_done = 1'b1;
    check_status("garbage_sync_data");

    do_reset();
    send(8'hA5); send(8'h00);
    exp_err = 1'b1;
    check_status("len_zero");
    b = 8'(DEPTH + 1);
    send(8'hA5); send(b);
    check_status("len_over");

    do_reset();
    send(8'hA5); send(8'h04);
    push_wr(0, 'h01);
    push_wr(1, 'h02);
    send(8'h01); send(8'h02);
    #1;
    chk("mid_pending_writes", exp_q.size(), 0);
    reset = 1'b0;
    #1;
    check_reset_values("mid_reset");
    @(negedge clk);
    exp_done = 1'b0;
    exp_err  = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    run_frame(0);
    check_status("after_mid_reset");

    rand_gaps = 1'b1;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0) do_reset();
      for (int g = int'($urandom_range(0, 3)); g > 0; g--) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        send(b);
      end
      run_frame(int'($urandom_range(0, 2)));
      check_status("rand");
    end
    rand_gaps = 1'b0;

    do_reset();
    send(8'hA5); send(8'h02);
    push_wr(0, 'h10);
    send(8'h10);
`ifdef PROGRAM_LOADER_TIMEOUT_EN
    seen = 0;
    for (int i = 1; i <= TO + 1; i++) begin
      @(negedge clk);
      if (seen == 0 && load_error) seen = i;
    end
    chk("timeout_flagged", int'(seen != 0), 1);
    chk("timeout_hold", int'(cpu_hold), 1);
    chk("timeout_done", int'(load_done), 0);
`else
    seen = 0;
    for (int i = 1; i <= 1000; i++) begin
      @(negedge clk);
      if (seen == 0 && load_error) seen = i;
    end
    chk("no_timeout_error_cycle", seen, 0);
    chk("no_timeout_hold", int'(cpu_hold), 1);
    chk("no_timeout_done", int'(load_done), 0);
`endif
    chk("timeout_pending_writes", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Upstream boot stage for the 8-bit SAP computer. Receives a framed program image as a byte stream from the UART receiver, writes it into program RAM from address 0, and holds the CPU in reset until a complete, checksum-verified image is loaded. It replaces the simulation-only memory preload with a hardware load path, so the CPU starts executing at address 0 on a verified image.

## Interface
- `ADDR_WIDTH`, default `arch_defs_pkg::ADDR_WIDTH`: RAM address width; RAM depth is `2**ADDR_WIDTH`.
- `TIMEOUT_CYCLES`, default 100000: inter-byte timeout in clocks. Used only when the timeout feature is compiled in.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `rx_data`  in  `DATA_WIDTH`  received byte.
- `rx_valid`  in  1  one-cycle strobe marking `rx_data` valid. There is no backpressure; every strobe is consumed.
- `ram_we`  out  1  RAM write enable, one-cycle pulse.
- `ram_addr`  out  `ADDR_WIDTH`  RAM write address.
- `ram_wdata`  out  `DATA_WIDTH`  RAM write data.
- `cpu_hold`  out  1  when 1, the CPU is kept in reset.
- `load_done`  out  1  image loaded and verified; sticky until reset.
- `load_error`  out  1  framing, length, checksum or timeout error.

## Operation
- Frame format: sync byte `0xA5`, then length byte N, then N data bytes, then checksum byte. The checksum is the 8-bit sum of the data bytes mod 256.
- State machine states: IDLE, LEN, DATA, CSUM, DONE, ERROR.
- IDLE:
  - `rx_valid` with `0xA5` goes to LEN; the data counter and running sum are cleared.
  - Any other byte is ignored.
- LEN:
  - N = 0 or N > `2**ADDR_WIDTH` goes to ERROR.
  - Otherwise N is latched and the block goes to DATA.
- DATA:
  - Each byte is written to address k, where k is the data counter starting at 0.
  - The running sum is updated with each byte.
  - The N-th byte moves the block to CSUM.
  - A `0xA5` byte in DATA is ordinary data.
- CSUM:
  - A byte equal to the running sum goes to DONE.
  - A mismatch goes to ERROR.
  - RAM contents already written are not rolled back.
- DONE: `cpu_hold` = 0 and `load_done` = 1. All further bytes are ignored until reset.
- ERROR:
  - `cpu_hold` = 1 and `load_error` = 1.
  - A `0xA5` byte restarts the load: `load_error` clears and the block goes to LEN.
  - Other bytes are ignored.
- Arithmetic:
  - The running sum is 8-bit and wraps.
  - The data counter is `ADDR_WIDTH`+1 bits, so N = `2**ADDR_WIDTH` is representable.
  - The address is the low `ADDR_WIDTH` bits of the counter.

## Timing
- Reset values:
  - State IDLE.
  - `ram_we` = 0, `ram_addr` = 0, `ram_wdata` = 0.
  - `cpu_hold` = 1, `load_done` = 0, `load_error` = 0.
  - Counters and sum = 0.
- All outputs are registered.
- Write latency: data byte strobed at edge t drives `ram_we` = 1 with its address and data during cycle t..t+1. `ram_we` returns to 0 on the next edge unless another data byte was strobed.
- Back-to-back `rx_valid` on consecutive cycles is supported. Each data byte produces one write.
- Done latency: checksum byte strobed at edge t sets `load_done` = 1 and `cpu_hold` = 0 at the same edge, so they are visible from t.
- Error flags assert at the edge that accepts the offending byte.
- Asserting reset mid-load aborts immediately to the reset values, and `cpu_hold` re-asserts. A partially written RAM is left as is.

## Configuration
- Macro `PROGRAM_LOADER_TIMEOUT_EN`.
- Defined:
  - A cycle counter runs in LEN, DATA and CSUM and clears on every `rx_valid`.
  - Reaching `TIMEOUT_CYCLES` with no byte moves the block to ERROR, with `load_error` = 1 the following cycle.
  - The counter is idle in IDLE, DONE and ERROR.
- Not defined:
  - No counter is built.
  - The block waits indefinitely between bytes.
  - `TIMEOUT_CYCLES` is unused.

## Structure
- `arch_defs_pkg` gains:
  - `LOADER_SYNC_BYTE` = 8'hA5.
  - `loader_state_t`, an enum of the six states.
- One sub-module, `loader_timeout_counter`, instantiated only under `PROGRAM_LOADER_TIMEOUT_EN`.
  - Inputs: `clk`, `reset`, `enable`, `clear`.
  - Output: `expired`.
- The top-level `computer` gates the CPU reset with `cpu_hold` and muxes the RAM write port from this block while `cpu_hold` = 1.

## Test plan
- Frame A5, 03, 11, 22, 33, 66 -> writes at addresses 0/1/2 with data 11/22/33; then `load_done` = 1, `cpu_hold` = 0, `load_error` = 0.
- Same frame with checksum 67 -> `load_error` = 1, `cpu_hold` = 1, `load_done` = 0; a following valid frame recovers to DONE.
- Garbage bytes 00, FF, 5A before A5, 01, A5, A5 -> garbage ignored; one write of A5 to address 0; then DONE.
- Length byte 00, and length `2**ADDR_WIDTH`+1 -> ERROR; no `ram_we` pulses.
- Reset pulsed low mid-DATA after 2 of 4 bytes -> all outputs at reset values; a fresh full frame then completes normally.
- With `PROGRAM_LOADER_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 20: A5, 02, 10, then silence -> `load_error` = 1 within 21 cycles of the last strobe. Without the macro, no error after 1000 cycles.
